// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with IDLE/BUSY/DONE handshake; define SERIAL_ADDER_SUB_EN to add the sub port (a-b mode)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic             sub_i, accept, last, s_bit, c_next;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  assign ready  = state_q != BUSY;
  assign busy   = state_q == BUSY;
  assign done   = state_q == DONE;
  assign sum    = sum_q;
  assign cout   = cout_q;
  assign accept = ready & start;
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign s_bit  = a_q[0] ^ b_q[0] ^ c_q;
  assign c_next = (a_q[0] & b_q[0]) | (b_q[0] & c_q) | (a_q[0] & c_q);
  // Next state: load operands on accept, otherwise shift one bit per BUSY cycle into sum from the top
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      state_d = BUSY;
      cnt_d   = '0;
      a_d     = a;
      b_d     = sub_i ? ~b : b;
      c_d     = sub_i | cin;
    end else if (busy) begin
      state_d = last ? DONE : BUSY;
      cnt_d   = cnt_q + CW'(1);
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      c_d     = c_next;
      sum_d   = {s_bit, sum_q[WIDTH-1:1]};
      cout_d  = last ? c_next : cout_q;
    end else if (done) begin
      state_d = IDLE;
    end
  end
  // State registers; reset aborts any operation in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8); define SERIAL_ADDER_SUB_EN to also exercise subtract
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic ready, busy, done, cout;
  int total = 0, bad = 0;
  logic [W:0] exp_q[$];
  logic [W:0] exp_e;
  int bc;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`endif
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Result monitor: every done pulse pops and checks the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done got=%h", {cout, sum});
      end else begin
        exp_e = exp_q.pop_front();
        if ({cout, sum} !== exp_e) begin
          bad++;
          $display("FAIL result got=%h want=%h", {cout, sum}, exp_e);
        end
      end
    end
  end

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s, input bit chk);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    if (chk) exp_q.push_back(model(x, y, ci, s));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, output int busy_n);
    int lat = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end while (!done && lat < 40);
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({ready, busy, done, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", {ready, busy, done, cout, sum}, {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_wrap();
    launch(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    wait_done("wrap", 9, bc);
  endtask

  task automatic test_carry_in();
    launch(8'h5A, 8'h25, 1'b1, 1'b0, 1'b1);
    wait_done("carry_in", 9, bc);
    total++;
    if (bc !== 8) begin
      bad++;
      $display("FAIL carry_in_busy_cycles got=%0d want=8", bc);
    end
  endtask

  task automatic test_start_busy();
    launch(8'h30, 8'h0C, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    a = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00;
    wait_done("start_busy", 5, bc);
    repeat (3) @(negedge clk);
    total++;
    if ({cout, sum} !== 9'h03C) begin
      bad++;
      $display("FAIL hold_result got=%h want=03c", {cout, sum});
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
    wait_done("b2b_first", 9, bc);
    a = 8'h01; b = 8'h02;
    exp_q.push_back(model(8'h01, 8'h02, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, ready} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_no_idle got busy,ready=%b want=10", {busy, ready});
    end
    wait_done("b2b_second", 8, bc);
  endtask

  task automatic test_reset_mid();
    launch(8'hAA, 8'h11, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready, busy, done, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%b want=%b", {ready, busy, done, cout, sum}, {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_ready got=%b want=1", ready);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("post_reset", 9, bc);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1);
      wait_done("random", 9, bc);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    launch(8'h03, 8'h05, 1'b0, 1'b1, 1'b1);
    wait_done("sub", 9, bc);
    launch(8'h09, 8'h04, 1'b1, 1'b1, 1'b1);
    wait_done("sub_no_borrow", 9, bc);
    launch(8'h03, 8'h05, 1'b1, 1'b0, 1'b1);
    wait_done("sub_off", 9, bc);
  endtask
`endif

  initial begin
    test_reset();
    test_carry_wrap();
    test_carry_in();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    repeat (12) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL pending_results got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
